// File: rtl/layer8_pkg.sv
// Shared widths, writeback FSM states and saturation limits for the layer-8 output stage.
// The optional skip-connection add is selected by the L8_SKIP_ADD_EN macro (see layer8_acc_writeback).
package layer8_pkg;

    localparam int PSUM_W_DEF = 32;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int FRAC_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SKIP_RD   = 3'd1,
        ST_SKIP_WAIT = 3'd2,
        ST_CALC      = 3'd3,
        ST_WRITE     = 3'd4
    } wb_state_t;

    // Signed saturation limits for a w-bit two's-complement result, held in 64 bits.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam logic signed [63:0] SAT_MAX_DEF = sat_max(DATA_W_DEF);
    localparam logic signed [63:0] SAT_MIN_DEF = sat_min(DATA_W_DEF);

endpackage

// File: rtl/layer8_sat_relu.sv
// Combinational post-processing: arithmetic shift, skip add, saturate to DATA_W, then ReLU.
// ovf flags a clamp; ReLU zeroing on its own is not an overflow.
module layer8_sat_relu
    import layer8_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic signed [PSUM_W-1:0] acc_final,
    input  logic signed [DATA_W-1:0] skip,
    output logic        [DATA_W-1:0] result,
    output logic                     ovf
);

    localparam logic signed [63:0] MAX64 = sat_max(DATA_W);
    localparam logic signed [63:0] MIN64 = sat_min(DATA_W);

    logic signed [PSUM_W-1:0] shifted;
    logic signed [63:0]       sum;

    // The sum is formed in 64 bits so the skip add itself can never wrap.
    always_comb begin
        shifted = acc_final >>> FRAC_W;
        sum     = {{(64-PSUM_W){shifted[PSUM_W-1]}}, shifted}
                + {{(64-DATA_W){skip[DATA_W-1]}}, skip};
        ovf     = 1'b0;
        if (sum > MAX64) begin
            result = MAX64[DATA_W-1:0];
            ovf    = 1'b1;
        end else if (sum < MIN64) begin
            result = MIN64[DATA_W-1:0];
            ovf    = 1'b1;
        end else begin
            result = sum[DATA_W-1:0];
        end
        if (result[DATA_W-1]) begin
            result = '0;
        end
    end

endmodule

// File: rtl/layer8_acc_writeback.sv
// Layer-8 output stage: accumulates partial sums per pixel, then post-processes and writes BRAM2.
// Define L8_SKIP_ADD_EN to include the skip-connection read and add; otherwise the skip path is absent.
module layer8_acc_writeback
    import layer8_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum_data,
    input  logic                     load,
    input  logic        [ADDR_W-1:0] wr_addr_in,
    input  logic        [ADDR_W-1:0] skip_addr_in,
    output logic                     skip_rd_en,
    output logic        [ADDR_W-1:0] skip_rd_addr,
    input  logic signed [DATA_W-1:0] skip_rd_data,
    output logic                     out_we,
    output logic        [ADDR_W-1:0] out_addr,
    output logic        [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     ovf_flag,
    output logic                     overrun_err
);

    wb_state_t                state;
    wb_state_t                state_next;
    logic signed [PSUM_W-1:0] acc;
    logic signed [PSUM_W-1:0] acc_final;
    logic signed [PSUM_W-1:0] fin_q;
    logic        [ADDR_W-1:0] waddr_q;
    logic signed [DATA_W-1:0] skip_term;
    logic        [DATA_W-1:0] sr_result;
    logic                     sr_ovf;
    logic                     load_acc;
    logic                     accept;
    logic                     calc_now;

    assign acc_final = acc + psum_data;
    assign load_acc  = psum_valid & load;
    assign accept    = load_acc & ~busy;
    assign calc_now  = (state == ST_SKIP_WAIT) || (state == ST_CALC);

`ifdef L8_SKIP_ADD_EN
    assign skip_term = skip_rd_data;
`else
    logic unused_skip;
    assign unused_skip = ^{skip_rd_data, skip_addr_in};
    assign skip_term   = '0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef L8_SKIP_ADD_EN
                    state_next = ST_SKIP_RD;
`else
                    state_next = ST_CALC;
`endif
                end
            end
            ST_SKIP_RD:   state_next = ST_SKIP_WAIT;
            ST_SKIP_WAIT: state_next = ST_WRITE;
            ST_CALC:      state_next = ST_WRITE;
            ST_WRITE:     state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    layer8_sat_relu #(
        .PSUM_W (PSUM_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_sat_relu (
        .acc_final (fin_q),
        .skip      (skip_term),
        .result    (sr_result),
        .ovf       (sr_ovf)
    );

    // Outputs are registered from next-state so each strobe lines up with its state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            acc         <= '0;
            fin_q       <= '0;
            waddr_q     <= '0;
            out_we      <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
            ovf_flag    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            if (psum_valid) begin
                acc <= load ? '0 : acc_final;
            end
            if (accept) begin
                fin_q   <= acc_final;
                waddr_q <= wr_addr_in;
            end
            // A load while busy still clears acc above but its final value is dropped.
            if (load_acc && busy) begin
                overrun_err <= 1'b1;
            end
            out_we   <= calc_now;
            out_addr <= calc_now ? waddr_q : '0;
            out_data <= calc_now ? sr_result : '0;
            if (calc_now && sr_ovf) begin
                ovf_flag <= 1'b1;
            end
        end
    end

`ifdef L8_SKIP_ADD_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            skip_rd_en   <= 1'b0;
            skip_rd_addr <= '0;
        end else begin
            skip_rd_en   <= (state_next == ST_SKIP_RD);
            skip_rd_addr <= (state_next == ST_SKIP_RD) ? skip_addr_in : '0;
        end
    end
`else
    assign skip_rd_en   = 1'b0;
    assign skip_rd_addr = '0;
`endif

endmodule

// File: tb/tb_layer8_acc_writeback.sv
// Self-checking bench for layer8_acc_writeback: table of single-pixel vectors plus hand sequences
// for overrun and mid-writeback reset. Expectations follow L8_SKIP_ADD_EN when it is defined.
module tb_layer8_acc_writeback;

`ifdef L8_SKIP_ADD_EN
    localparam bit SKIP_EN = 1'b1;
    localparam int LAT     = 3;
`else
    localparam bit SKIP_EN = 1'b0;
    localparam int LAT     = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psum_valid = 1'b0;
    logic [31:0] psum_data = '0;
    logic        load = 1'b0;
    logic [9:0]  wr_addr_in = '0;
    logic [9:0]  skip_addr_in = '0;
    logic        skip_rd_en;
    logic [9:0]  skip_rd_addr;
    logic [15:0] skip_rd_data = '0;
    logic        out_we;
    logic [9:0]  out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        ovf_flag;
    logic        overrun_err;

    logic [15:0] skip_mem [0:1023];
    logic [15:0] exp_q [$];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] pre1;
        logic [31:0] pre2;
        logic [31:0] fin;
        logic [15:0] skip;
        logic [9:0]  waddr;
        logic [9:0]  saddr;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    layer8_acc_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .psum_valid   (psum_valid),
        .psum_data    (psum_data),
        .load         (load),
        .wr_addr_in   (wr_addr_in),
        .skip_addr_in (skip_addr_in),
        .skip_rd_en   (skip_rd_en),
        .skip_rd_addr (skip_rd_addr),
        .skip_rd_data (skip_rd_data),
        .out_we       (out_we),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .busy         (busy),
        .ovf_flag     (ovf_flag),
        .overrun_err  (overrun_err)
    );

    // Clock and skip BRAM model (1-cycle read latency).
    always #5 clk = ~clk;

    always @(posedge clk) skip_rd_data <= skip_mem[skip_rd_addr];

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_we"}, out_we, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_skip_rd_en"}, skip_rd_en, 0);
        check({tag, "_skip_rd_addr"}, skip_rd_addr, 0);
        check({tag, "_ovf"}, ovf_flag, 0);
        check({tag, "_overrun"}, overrun_err, 0);
    endtask

    // One pixel: two plain terms then the load term, then watch six cycles of writeback.
    task automatic run_pixel(input vec_t v, input string tag);
        int rd_cyc;
        int we_cyc;
        int n_we;
        logic [9:0]  rd_addr;
        logic [9:0]  we_addr;
        logic [15:0] we_data;
        skip_mem[v.saddr] = v.skip;
        exp_q.push_back(v.exp_data);
        psum_valid = 1'b1; load = 1'b0; psum_data = v.pre1;
        tick();
        psum_data = v.pre2;
        tick();
        psum_data = v.fin; load = 1'b1;
        wr_addr_in = v.waddr; skip_addr_in = v.saddr;
        tick();
        psum_valid = 1'b0; load = 1'b0; psum_data = '0;
        rd_cyc = -1; we_cyc = -1; n_we = 0;
        rd_addr = '0; we_addr = '0; we_data = '0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) check({tag, "_busy_t1"}, busy, 1);
            if (skip_rd_en && rd_cyc < 0) begin
                rd_cyc  = c;
                rd_addr = skip_rd_addr;
            end
            if (out_we) begin
                n_we++;
                we_cyc  = c;
                we_addr = out_addr;
                we_data = out_data;
            end
            tick();
        end
        check({tag, "_we_count"}, n_we, 1);
        check({tag, "_we_cycle"}, we_cyc, LAT);
        check({tag, "_addr"}, we_addr, v.waddr);
        if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
        end else begin
            check({tag, "_data"}, we_data, exp_q.pop_front());
        end
`ifdef L8_SKIP_ADD_EN
        check({tag, "_rd_cycle"}, rd_cyc, 1);
        check({tag, "_rd_addr"}, rd_addr, v.saddr);
`else
        check({tag, "_rd_never"}, rd_cyc, -1);
`endif
        check({tag, "_ovf"}, ovf_flag, v.exp_ovf);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_data"}, out_data, 0);
    endtask

    task automatic sample_we(inout int n_we, inout logic [9:0] a, inout logic [15:0] d);
        if (out_we) begin
            n_we++;
            a = out_addr;
            d = out_data;
        end
    endtask

    initial begin
        int          n_we;
        logic [9:0]  we_addr;
        logic [15:0] we_data;
        vec_t        v;

        for (int i = 0; i < 1024; i++) skip_mem[i] = '0;

        // Expected data: skip-enabled value vs shift-only value, each worked by hand.
        vecs[0] = '{32'd256, 32'd512, 32'd768, 16'd100, 10'd37, 10'd5,
                    SKIP_EN ? 16'd106 : 16'd6, 1'b0};
        vecs[1] = '{32'd0, 32'd0, 32'hFFFF_F600, 16'd3, 10'd38, 10'd6, 16'd0, 1'b0};
        vecs[2] = '{32'd0, 32'd0, 32'd256, 16'hFFFB, 10'd39, 10'd7,
                    SKIP_EN ? 16'd0 : 16'd1, 1'b0};
        vecs[3] = '{32'd0, 32'd0, 32'h007F_FF00, 16'd1, 10'd40, 10'd8, 16'd32767, SKIP_EN};
        vecs[4] = '{32'd0, 32'd0, 32'h0100_0000, 16'd0, 10'd41, 10'd9, 16'd32767, 1'b1};
        vecs[5] = '{32'd0, 32'd0, 32'd1024, 16'd7, 10'd42, 10'd10,
                    SKIP_EN ? 16'd11 : 16'd4, 1'b1};
        vecs[6] = '{32'd0, 32'd0, 32'h8000_0000, 16'd0, 10'd1023, 10'd1023, 16'd0, 1'b1};
        vecs[7] = '{32'd100, 32'd200, 32'hFFFF_FFD4, 16'h7FFF, 10'd0, 10'd0,
                    SKIP_EN ? 16'd32767 : 16'd1, 1'b1};

        // Reset state.
        rst = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b1;
        tick();

        // load without psum_valid must not start a writeback.
        load = 1'b1; psum_valid = 1'b0; psum_data = 32'd5000;
        tick();
        load = 1'b0; psum_data = '0;
        tick();
        check("load_no_valid_busy", busy, 0);
        check("load_no_valid_we", out_we, 0);

        for (int i = 0; i < 8; i++) begin
            run_pixel(vecs[i], $sformatf("vec%0d", i));
        end

        // Overrun: loads at T and T+1, plain term at T+2 must start a fresh accumulation.
        rst = 1'b0; tick(); rst = 1'b1; tick();
        skip_mem[200] = 16'd0;
        exp_q.push_back(16'd2);
        n_we = 0; we_addr = '0; we_data = '0;
        psum_valid = 1'b1; load = 1'b1; psum_data = 32'd512;
        wr_addr_in = 10'd100; skip_addr_in = 10'd200;
        tick();
        sample_we(n_we, we_addr, we_data);
        psum_data = 32'h7FFF_0000; wr_addr_in = 10'd101; skip_addr_in = 10'd201;
        tick();
        sample_we(n_we, we_addr, we_data);
        psum_data = 32'd256; load = 1'b0;
        tick();
        sample_we(n_we, we_addr, we_data);
        psum_valid = 1'b0; psum_data = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            sample_we(n_we, we_addr, we_data);
        end
        check("ovr_we_count", n_we, 1);
        check("ovr_addr", we_addr, 10'd100);
        check("ovr_data", we_data, exp_q.pop_front());
        check("ovr_err", overrun_err, 1);
        check("ovr_busy", busy, 0);
        v = '{32'd0, 32'd0, 32'd0, 16'd0, 10'd102, 10'd202, 16'd1, 1'b0};
        run_pixel(v, "ovr_restart");
        check("ovr_err_sticky", overrun_err, 1);

        // Reset mid-writeback: the pending write must never appear.
        skip_mem[300] = 16'd50;
        n_we = 0; we_addr = '0; we_data = '0;
        psum_valid = 1'b1; load = 1'b1; psum_data = 32'd2560;
        wr_addr_in = 10'd55; skip_addr_in = 10'd300;
        tick();
        psum_valid = 1'b0; load = 1'b0; psum_data = '0;
        sample_we(n_we, we_addr, we_data);
        if (LAT == 3) begin
            tick();
            sample_we(n_we, we_addr, we_data);
        end
        rst = 1'b0;
        tick();
        sample_we(n_we, we_addr, we_data);
        check_outputs_zero("rst_mid");
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            sample_we(n_we, we_addr, we_data);
        end
        check("rst_mid_no_write", n_we, 0);
        check("rst_mid_busy", busy, 0);
        v = '{32'd0, 32'd0, 32'd1280, 16'd2, 10'd56, 10'd301,
              SKIP_EN ? 16'd7 : 16'd5, 1'b0};
        run_pixel(v, "post_rst");
        check("post_rst_overrun", overrun_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
